// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide responder.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam logic [4:0] OP_MULT  = 5'b00110;
  localparam logic [4:0] OP_DIV   = 5'b00111;
  localparam logic [3:0] EXC_MULT = 4'd4;
  localparam logic [3:0] EXC_DIV  = 4'd5;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter with clear/enable and a terminal-count flag at WIDTH-1.
module multdiv_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_responder.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine,
// answering a start pulse with a one-cycle result-ready strobe.
module multdiv_responder
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t state, state_nx;

  logic             start, pend, is_div, sa, sb, neg;
  logic [WIDTH-1:0] ra, rb, ma, mb;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign neg   = sa ^ sb;
  assign ma    = sa ? (~ra + 1'b1) : ra;
  assign mb    = sb ? (~rb + 1'b1) : rb;

  multdiv_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clear(pend),
    .en   (state == RUN),
    .count(cnt),
    .tc   (tc)
  );

  // One radix-2 step for each operation
  logic [WIDTH:0]   add;
  logic [2*WIDTH:0] mshift;
  logic [WIDTH:0]   dsh;
  logic [WIDTH+1:0] dtr;
  logic             dge;

  assign add    = hi + {1'b0, ma};
  assign mshift = {(lo[0] ? add : hi), lo} >> 1;
  assign dsh    = {hi[WIDTH-1:0], lo[WIDTH-1]};
  assign dtr    = {1'b0, dsh} - {2'b00, mb};
  assign dge    = ~dtr[WIDTH+1];

  // Sign correction and exception
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH:0]     top;
  logic [WIDTH-1:0]   sq, res_fix;
  logic               exc_fix;

  assign prod  = {hi[WIDTH-1:0], lo};
  assign sprod = neg ? (~prod + 1'b1) : prod;
  assign top   = sprod[2*WIDTH-1:WIDTH-1];
  assign sq    = neg ? (~lo + 1'b1) : lo;

  always_comb begin
    res_fix = sprod[WIDTH-1:0];
    exc_fix = ~((&top) | ~(|top));
    if (is_div) begin
      if (mb == '0) begin
        res_fix = '0;
        exc_fix = 1'b1;
      end else begin
        res_fix = sq;
        exc_fix = ~neg & lo[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend           <= 1'b0;
      is_div         <= 1'b0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      ra             <= '0;
      rb             <= '0;
      hi             <= '0;
      lo             <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      pend   <= 1'b1;
      is_div <= ~ctrl_MULT;
      ra     <= data_operandA;
      rb     <= data_operandB;
      sa     <= data_operandA[WIDTH-1];
      sb     <= data_operandB[WIDTH-1];
    end else begin
      pend <= 1'b0;
      if (pend) begin
        hi <= '0;
        lo <= is_div ? ma : mb;
      end else if (state == RUN) begin
        if (is_div) begin
          hi <= dge ? dtr[WIDTH:0] : dsh;
          lo <= {lo[WIDTH-2:0], dge};
        end else begin
          {hi, lo} <= mshift;
        end
      end else if (state == FIX) begin
        data_result    <= res_fix;
        data_exception <= exc_fix;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    data_resultRDY = 1'b0;
    busy           = 1'b0;
    unique case (state)
      IDLE: if (pend) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (tc) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A new start aborts whatever is in flight
    if (start) state_nx = IDLE;
  end

endmodule

// File: tb/tb_multdiv_responder.sv
// Scoreboard bench: directed ops push expectations, a monitor checks each RDY.
module tb_multdiv_responder;

  logic        clk = 0;
  logic        reset;
  logic [31:0] opa, opb;
  logic        mult, div;
  logic [31:0] result;
  logic        exc, rdy, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bcnt  = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          k;
  } exp_t;

  exp_t q[$];

  multdiv_responder #(.WIDTH(32), .CNT_W(6)) dut (
    .clock         (clk),
    .reset         (reset),
    .data_operandA (opa),
    .data_operandB (opb),
    .ctrl_MULT     (mult),
    .ctrl_DIV      (div),
    .data_result   (result),
    .data_exception(exc),
    .data_resultRDY(rdy),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && cyc >= q[0].k && busy === 1'b1) bcnt++;
    if (rdy === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_rdy", 64'(rdy), 64'd0);
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("exception", 64'(exc), 64'(e.exc));
        chk("latency", 64'(cyc - e.k), 64'd34);
        chk("busy_cycles", 64'(bcnt), 64'd33);
      end
      bcnt = 0;
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic m, input logic d,
                    input logic [31:0] r, input logic e, input bit push);
    exp_t x;
    @(negedge clk);
    opa  = a;
    opb  = b;
    mult = m;
    div  = d;
    if (push) begin
      x.res = r;
      x.exc = e;
      x.k   = cyc + 1;
      bcnt  = 0;
      q.push_back(x);
    end
    @(negedge clk);
    mult = 0;
    div  = 0;
    opa  = 32'hdeadbeef;
    opb  = 32'h0badf00d;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no rdy, want rdy within 60 cycles");
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdy"}, 64'(rdy), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_exc"}, 64'(exc), 64'd0);
  endtask

  initial begin
    reset = 1;
    opa   = 0;
    opb   = 0;
    mult  = 0;
    div   = 0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    reset = 0;

    op(32'd6, 32'd7, 1, 0, 32'd42, 0, 1);                         drain();
    op(32'hFFFFFFFD, 32'd5, 1, 0, 32'hFFFFFFF1, 0, 1);            drain();
    op(32'h00010000, 32'h00010000, 1, 0, 32'h0, 1, 1);            drain();
    op(32'h80000000, 32'd1, 1, 0, 32'h80000000, 0, 1);            drain();
    op(32'd7, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFD, 0, 1);            drain();
    op(32'hFFFFFFF8, 32'd2, 0, 1, 32'hFFFFFFFC, 0, 1);            drain();
    op(32'd123, 32'd0, 0, 1, 32'h0, 1, 1);                        drain();
    op(32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h80000000, 1, 1);     drain();

    // Restart: the MULT is aborted, only the DIV answers
    op(32'd2, 32'd3, 1, 0, 32'd6, 0, 0);
    repeat (8) @(negedge clk);
    op(32'd100, 32'd7, 0, 1, 32'd14, 0, 1);                       drain();

    op(32'd9, 32'd3, 1, 1, 32'd27, 0, 1);                         drain();

    // Reset in the middle of a MULT
    op(32'd11, 32'd13, 1, 0, 32'd143, 0, 0);
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_cleared("midreset");
    reset = 0;
    repeat (45) @(negedge clk);

    // Start coinciding with reset is dropped
    @(negedge clk);
    reset = 1;
    mult  = 1;
    opa   = 32'd5;
    opb   = 32'd5;
    @(negedge clk);
    reset = 0;
    mult  = 0;
    chk_cleared("rst_start");
    repeat (45) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
